// File: rtl/led_pattern_sequencer.sv
// Steps a ROM read address through a programmable window at a programmable rate
// and registers each fetched word onto the LEDs; supports pause, stop, loop and one-shot.
module led_pattern_sequencer #(
    parameter int AW     = 5,
    parameter int DW     = 5,
    parameter int RATE_W = 21
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [AW-1:0]     first_addr,
    input  logic [AW-1:0]     last_addr,
    input  logic [RATE_W-1:0] rate,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic [DW-1:0]     leds,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t            state;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] rate_q;
    logic [AW-1:0]     first_q;
    logic [AW-1:0]     last_q;
    logic              busy_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            rate_q   <= '0;
            first_q  <= '0;
            last_q   <= '0;
            busy_d   <= 1'b0;
            rom_addr <= '0;
            leds     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            // busy delayed one cycle lines up with the ROM's read latency, so the
            // final word of a one-shot still lands after busy drops
            busy_d <= busy;
            if (busy_d)
                leds <= rom_data;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (first_addr <= last_addr) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            first_q  <= first_addr;
                            last_q   <= last_addr;
                            rate_q   <= rate;
                            rom_addr <= first_addr;
                            cnt      <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        busy_d <= 1'b0;
                        leds   <= '0;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        // the edge that leaves PAUSE counts like any RUN cycle
                        state <= RUN;
                        if (cnt == rate_q) begin
                            cnt <= '0;
                            if (rom_addr == last_q) begin
                                if (loop_en) begin
                                    rom_addr <= first_q;
                                    wrap     <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
